// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for the sync_fifo read-side adapter: pointer, occupancy
// and credit widths derived from a buffer depth, plus the minimum legal depth.
package sync_fifo_pkg;

    localparam int BUF_DEPTH_MIN = 2;

    // Pointers wrap explicitly at depth-1, so non power-of-two depths are legal.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counts 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Credit sum occ + pend can reach depth + 1 transiently in the compare.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// Bundles the sync_fifo read port and the outgoing valid/ready stream.
// master = adapter side, slave = FIFO plus stream consumer side.
interface fifo_rd_stream_adapter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_r_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_r_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_r_en, m_valid, m_data
    );
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Circular buffer of BUF_DEPTH entries that absorbs the FIFO read latency.
// Head entry is presented combinationally; occupancy is exported for credit.
module fifo_rd_skid_buf
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 3,
    localparam int PTR_W     = ptr_width(BUF_DEPTH),
    localparam int OCC_W     = occ_width(BUF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [OCC_W-1:0]      occ
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [OCC_W-1:0]      occ_reg;
    logic [OCC_W-1:0]      occ_next;
    logic                  pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign rd_valid = (occ_reg != '0);
    assign pop      = rd_valid && rd_ready;
    // Masked to zero while empty so the stream data reads 0 out of reset.
    assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;
    assign occ      = occ_reg;

    always_comb begin
        occ_next = occ_reg;
        if (wr_en && !pop) begin
            occ_next = occ_reg + OCC_W'(1);
        end else if (!wr_en && pop) begin
            occ_next = occ_reg - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            occ_reg <= occ_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // The credit rule upstream guarantees a capture never lands in a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && (occ_reg == OCC_W'(BUF_DEPTH))));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read stage for sync_fifo: issues r_en on credit, captures the 1-cycle-late data
// and streams it out via valid/ready. Optional beat counter: FIFO_RD_ADAPT_CNT_EN.
module fifo_rd_stream_adapter
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fifo_rd_stream_adapter_if.master   bus
`ifdef FIFO_RD_ADAPT_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]       m_beat_cnt
`endif
);

    localparam int OCC_W    = occ_width(BUF_DEPTH);
    localparam int CREDIT_W = credit_width(BUF_DEPTH);

    generate
        if (BUF_DEPTH < BUF_DEPTH_MIN || CNT_WIDTH < 1) begin : g_bad_params
            $error("fifo_rd_stream_adapter: illegal BUF_DEPTH or CNT_WIDTH");
        end
    endgenerate

    logic                pend_reg;
    logic [OCC_W-1:0]    occ;
    logic [CREDIT_W-1:0] credit_used;
    logic                pop;

    // Credit uses only registered terms, so m_ready never reaches fifo_r_en.
    assign credit_used   = CREDIT_W'(occ) + CREDIT_W'(pend_reg);
    assign bus.fifo_r_en = rst_n && !bus.fifo_empty &&
                           (credit_used < CREDIT_W'(BUF_DEPTH));
    assign pop           = bus.m_valid && bus.m_ready;

    // A granted read means fifo_data carries a fresh beat next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg <= 1'b0;
        end else begin
            pend_reg <= bus.fifo_r_en;
        end
    end

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (pend_reg),
        .wr_data  (bus.fifo_data),
        .rd_ready (bus.m_ready),
        .rd_valid (bus.m_valid),
        .rd_data  (bus.m_data),
        .occ      (occ)
    );

`ifdef FIFO_RD_ADAPT_CNT_EN
    logic [CNT_WIDTH-1:0] beat_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_reg <= '0;
        end else if (pop) begin
            beat_cnt_reg <= beat_cnt_reg + CNT_WIDTH'(1);
        end
    end

    assign m_beat_cnt = beat_cnt_reg;
`else
    logic unused_pop;
    assign unused_pop = pop;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter with a behavioural sync_fifo read port
// and an in-order scoreboard on the stream side.
module tb_fifo_rd_stream_adapter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fifo_rd_stream_adapter_if #(.DATA_WIDTH(8)) bus ();

`ifdef FIFO_RD_ADAPT_CNT_EN
    logic [3:0] m_beat_cnt;
`endif

    fifo_rd_stream_adapter #(
        .DATA_WIDTH (8),
        .BUF_DEPTH  (3),
        .CNT_WIDTH  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FIFO_RD_ADAPT_CNT_EN
        ,
        .m_beat_cnt (m_beat_cnt)
`endif
    );

    int total = 0;
    int bad = 0;
    int push_cnt = 0;
    int pop_cnt;
    int rx_cnt = 0;
    int rd_issued = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] src_data [1024];

    // sync_fifo model: registered data_out, pops only on r_en && !empty.
    assign bus.fifo_empty = (push_cnt == pop_cnt);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_cnt       <= 0;
            bus.fifo_data <= 8'h00;
        end else if (bus.fifo_r_en && (pop_cnt != push_cnt)) begin
            bus.fifo_data <= src_data[pop_cnt];
            pop_cnt       <= pop_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        src_data[push_cnt] = d;
        push_cnt++;
    endtask

    // One clock: checks at the falling edge, returns just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            check_val("ren_when_empty", 32'(bus.fifo_r_en && bus.fifo_empty), 32'd0);
            check_val("occ_bound", 32'(dut.u_buf.occ_reg <= 2'd3), 32'd1);
            if (prev_stall) begin
                check_val("valid_hold", 32'(bus.m_valid), 32'd1);
                check_val("data_hold", 32'(bus.m_data), 32'(prev_data));
            end
            if (bus.fifo_r_en) rd_issued++;
            if (bus.m_valid && bus.m_ready) begin
                if (rx_cnt < push_cnt) begin
                    check_val("data_order", 32'(bus.m_data), 32'(src_data[rx_cnt]));
                end else begin
                    check_val("extra_beat", 32'(rx_cnt), 32'(push_cnt));
                end
                rx_cnt++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_reset();
        rst_n       = 1'b0;
        push_cnt    = 0;
        rx_cnt      = 0;
        rd_issued   = 0;
        prev_stall  = 1'b0;
        bus.m_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic drain(input string tag, input int target, input int budget);
        for (int c = 0; c < budget && rx_cnt < target; c++) tick();
        check_val(tag, 32'(rx_cnt), 32'(target));
    endtask

    initial begin
        bus.m_ready = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset with four beats waiting in the FIFO
        start_reset();
        for (int i = 0; i < 4; i++) push(8'(i + 1));
        tick();
        check_val("rst_ren", 32'(bus.fifo_r_en), 32'd0);
        check_val("rst_valid", 32'(bus.m_valid), 32'd0);
        check_val("rst_data", 32'(bus.m_data), 32'd0);
        bus.m_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        check_val("t1_ren_first", 32'(bus.fifo_r_en), 32'd1);
        check_val("t1_valid_c0", 32'(bus.m_valid), 32'd0);
        tick();
        check_val("t1_valid_c1", 32'(bus.m_valid), 32'd0);
        tick();
        check_val("t1_valid_c2", 32'(bus.m_valid), 32'd1);
        check_val("t1_data_c2", 32'(bus.m_data), 32'h01);
        drain("t1_drain", 4, 20);

        // 2: eight preloaded beats at full throughput
        start_reset();
        for (int i = 0; i < 8; i++) push(8'(i + 1));
        bus.m_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            check_val("t2_valid", 32'(bus.m_valid), 32'd1);
            check_val("t2_data", 32'(bus.m_data), 32'(i + 1));
            tick();
        end
        tick();
        check_val("t2_idle_valid", 32'(bus.m_valid), 32'd0);
        check_val("t2_count", 32'(rx_cnt), 32'd8);

        // 3: stalled consumer, five beats available
        start_reset();
        for (int i = 0; i < 5; i++) push(8'(i + 1));
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check_val("t3_reads_stalled", 32'(rd_issued), 32'd3);
        check_val("t3_valid", 32'(bus.m_valid), 32'd1);
        check_val("t3_head", 32'(bus.m_data), 32'h01);
        bus.m_ready = 1'b1;
        drain("t3_drain", 5, 30);
        check_val("t3_reads_total", 32'(rd_issued), 32'd5);

        // 4: random fill and random backpressure over 1000 beats
        start_reset();
        rst_n = 1'b1;
        for (int c = 0; c < 30000 && rx_cnt < 1000; c++) begin
            if (push_cnt < 1000 && ($urandom_range(1, 0) == 1)) begin
                int n = $urandom_range(3, 1);
                for (int k = 0; k < n && push_cnt < 1000; k++) push(8'($urandom));
            end
            bus.m_ready = ($urandom_range(1, 0) == 1);
            tick();
        end
        check_val("t4_beats", 32'(rx_cnt), 32'd1000);

        // 5: reset mid-stream with occ=2, pend=1
        start_reset();
        for (int i = 0; i < 5; i++) push(8'(i + 16));
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check_val("t5_pre_occ", 32'(dut.u_buf.occ_reg), 32'd2);
        check_val("t5_pre_pend", 32'(dut.pend_reg), 32'd1);
        check_val("t5_pre_valid", 32'(bus.m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("t5_valid", 32'(bus.m_valid), 32'd0);
        check_val("t5_ren", 32'(bus.fifo_r_en), 32'd0);
        check_val("t5_occ", 32'(dut.u_buf.occ_reg), 32'd0);
        check_val("t5_wr_ptr", 32'(dut.u_buf.wr_ptr_reg), 32'd0);
        check_val("t5_rd_ptr", 32'(dut.u_buf.rd_ptr_reg), 32'd0);
        check_val("t5_pend", 32'(dut.pend_reg), 32'd0);
        check_val("t5_data", 32'(bus.m_data), 32'd0);

`ifdef FIFO_RD_ADAPT_CNT_EN
        // 6: 4-bit beat counter wraps after 16, stalls do not count
        start_reset();
        check_val("t6_cnt_reset", 32'(m_beat_cnt), 32'd0);
        for (int i = 0; i < 17; i++) push(8'(i + 32));
        rst_n = 1'b1;
        for (int c = 0; c < 200 && rx_cnt < 17; c++) begin
            bus.m_ready = (c % 3 != 0);
            tick();
        end
        check_val("t6_beats", 32'(rx_cnt), 32'd17);
        bus.m_ready = 1'b0;
        tick();
        tick();
        check_val("t6_cnt_wrap", 32'(m_beat_cnt), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
